// File: rtl/cache_arbiter.sv
// Round-robin arbiter: I-cache and D-cache share one physical memory port; pmem command one cycle after an IDLE request.
// Requests are level-held until resp. The loser waits, and each resp is followed by one forced IDLE cycle.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_d;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              i_req, d_req, grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the side that did not win last time gets the port.
  assign grant_d = (state == IDLE) && d_req && (!i_req || !last_d);
  assign grant_i = (state == IDLE) && i_req && (!d_req || last_d);

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        last_d    <= 1'b1;
        lat_write <= d_write;
        lat_addr  <= d_address;
        lat_wdata <= d_wdata;
      end else if (grant_i) begin
        last_d    <= 1'b0;
        lat_write <= 1'b0;
        lat_addr  <= i_address;
        lat_wdata <= '0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = lat_addr;
        if (pmem_resp) begin
          i_resp    = 1'b1;
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        // A writeback latched together with a read is issued as a write only.
        pmem_write   = lat_write;
        pmem_read    = !lat_write;
        pmem_address = lat_addr;
        pmem_wdata   = lat_wdata;
        if (pmem_resp) begin
          d_resp    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_W, 256, cacheline width in bits for all line data ports.
REQ-002 Parameter: ADDR_W, 32, address width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 i_read  input  1  I-cache line read request, level-held until i_resp.
REQ-006 i_address  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  line data returned to I-cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to I-cache.
REQ-009 d_read  input  1  D-cache line read request, level-held until d_resp.
REQ-010 d_write  input  1  D-cache line writeback request, level-held until d_resp.
REQ-011 d_address  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  D-cache writeback line.
REQ-013 d_rdata  output  LINE_W  line data returned to D-cache.
REQ-014 d_resp  output  1  one-cycle completion pulse to D-cache.
REQ-015 pmem_read  output  1  read command to the single physical memory port.
REQ-016 pmem_write  output  1  write command to physical memory.
REQ-017 pmem_address  output  ADDR_W  physical memory address.
REQ-018 pmem_wdata  output  LINE_W  physical memory write line.
REQ-019 pmem_rdata  input  LINE_W  physical memory read line, valid with pmem_resp.
REQ-020 pmem_resp  input  1  physical memory completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, SERVE_I, SERVE_D; exactly one active per cycle.
REQ-022 IDLE: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=d_resp=0.
REQ-023 IDLE with only i_read=1 -> SERVE_I next cycle; only (d_read|d_write)=1 -> SERVE_D next cycle.
REQ-024 IDLE with both requesting: grant the requester NOT in register last_grant (round-robin); last_grant resets to I, so D wins first tie.
REQ-025 On every transition IDLE->SERVE_x: latch requester address (and d_wdata, and op type) into internal registers; update last_grant to x.
REQ-026 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=latched address, held until pmem_resp.
REQ-027 SERVE_D: pmem_write=1 if latched op is write else pmem_read=1; pmem_address/pmem_wdata from latches; held until pmem_resp.
REQ-028 d_read and d_write both 1 at grant: write SHALL take precedence; d_read ignored.
REQ-029 In SERVE_x with pmem_resp=1: x_resp=1 same cycle (combinational), x_rdata=pmem_rdata same cycle, next state IDLE.
REQ-030 i_rdata/d_rdata SHALL equal pmem_rdata at all times; only x_resp qualifies validity.
REQ-031 Non-granted requester's resp SHALL stay 0; its request is held and served after the current transaction.
REQ-032 Mandatory IDLE cycle after each resp (no back-to-back grant), giving requester one cycle to drop its request.
REQ-033 pmem_resp while IDLE SHALL be ignored (no resp, no state change).
REQ-034 Requester input changes during SERVE_x SHALL not affect pmem outputs (latched values used).
REQ-035 Min latency: request in IDLE cycle N -> pmem command cycle N+1; resp cycle = pmem_resp cycle.

Reset
REQ-036 rst=0 at a clock edge: state=IDLE, last_grant=I, latches cleared to 0, next cycle all outputs per REQ-022.
REQ-037 Reset mid-transaction SHALL abort it without issuing resp; draining physical memory is the system's responsibility.

Verification
REQ-038 Lone I read 0x0000_1000, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 for 3 cycles, i_resp one pulse with i_rdata=0xA5..A5, d_resp=0.
REQ-039 Simultaneous i_read and d_write from reset -> D served first (pmem_write=1, address=d_address), then IDLE one cycle, then I served.
REQ-040 Both held continuously for 4 transactions -> grant order D,I,D,I; exactly one IDLE cycle between each.
REQ-041 d_address changed 0x200->0x300 during SERVE_D -> pmem_address stays 0x200 until d_resp.
REQ-042 rst=0 asserted during SERVE_I, then pmem_resp=1 after reset released -> no i_resp, state IDLE, all pmem outputs 0.
REQ-043 d_read=d_write=1 at grant -> pmem_write=1, pmem_read=0 for the whole transaction.
